// File: rtl/uart_frame_packetizer.sv
// uart_frame_packetizer
//   Buffers camera bytes in a FIFO and emits each frame to the UART TX side as
//   A5 5A seq <payload> checksum drop_count over a valid/ready handshake.
// Ports:
//   sys_clk, rst_n           clock, asynchronous active-low reset
//   frame_start, frame_end   single-cycle frame delimiters from the camera
//   in_valid, in_data        camera byte strobe (cannot be stalled)
//   tx_valid, tx_data        output byte, held stable until tx_ready
//   tx_ready                 UART side accepts the byte
//   busy                     state is not IDLE
//   frame_seq                sequence number of the current or next frame
//   drop_count               bytes lost to FIFO overflow in this frame (saturating)
module uart_frame_packetizer #(
  parameter logic [7:0]  HDR0   = 8'hA5,
  parameter logic [7:0]  HDR1   = 8'h5A,
  parameter int unsigned ADDR_W = 8
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] frame_seq,
  output logic [7:0] drop_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_SEQ,
    S_PAYLOAD,
    S_TRL_SUM,
    S_TRL_DROP
  } state_t;

  state_t            state_q, state_d;
  logic              accept_q, accept_d;
  logic              end_pending_q, end_pending_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [7:0]        frame_seq_d, drop_count_d, tx_data_d, head_c;
  logic              tx_valid_d, busy_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_base_c;
  logic [CNT_W-1:0]  count_q, count_d, count_base_c, count_left_c;
  logic              start_c, accept_eff_c, full_c, wr_en_c, drop_c, hs_c, pop_c;

  logic [7:0] mem [DEPTH];

  // A frame_start in IDLE flushes the FIFO and opens the frame on the same edge,
  // so a byte arriving with it already belongs to the new frame.
  assign start_c      = (state_q == S_IDLE) && frame_start;
  assign accept_eff_c = accept_q || start_c;
  assign rd_base_c    = start_c ? wr_ptr_q : rd_ptr_q;
  assign count_base_c = start_c ? '0 : count_q;
  // Full is judged before any same-cycle pop.
  assign full_c       = (count_base_c == CNT_W'(DEPTH));
  assign wr_en_c      = in_valid && accept_eff_c && !full_c;
  assign drop_c       = in_valid && accept_eff_c && full_c;
  assign hs_c         = tx_valid && tx_ready;
  assign pop_c        = hs_c && (state_q == S_PAYLOAD);
  assign count_left_c = count_base_c - CNT_W'(pop_c);

  // Next-state and frame bookkeeping
  always_comb begin
    state_d       = state_q;
    accept_d      = accept_q;
    end_pending_d = end_pending_q;
    checksum_d    = checksum_q;
    frame_seq_d   = frame_seq;
    drop_count_d  = drop_count;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d      = S_HDR0;
          accept_d     = 1'b1;
          checksum_d   = '0;
          drop_count_d = '0;
        end
      end
      S_HDR0: if (hs_c) state_d = S_HDR1;
      S_HDR1: if (hs_c) state_d = S_SEQ;
      S_SEQ:  if (hs_c) state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (pop_c) checksum_d = checksum_q + tx_data;
        // Only sampled on an empty FIFO, so the exit lands the cycle after the last pop.
        if (end_pending_q && (count_q == '0)) state_d = S_TRL_SUM;
      end
      S_TRL_SUM: if (hs_c) state_d = S_TRL_DROP;
      S_TRL_DROP: begin
        if (hs_c) begin
          state_d       = S_IDLE;
          end_pending_d = 1'b0;
          frame_seq_d   = frame_seq + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && accept_q && frame_end) begin
      accept_d      = 1'b0;
      end_pending_d = 1'b1;
    end

    if (drop_c && (drop_count_d != 8'hFF)) drop_count_d = drop_count_d + 8'd1;
  end

  // FIFO pointers and the registered output byte for the upcoming state
  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en_c);
    rd_ptr_d = rd_base_c + ADDR_W'(pop_c);
    count_d  = count_left_c + CNT_W'(wr_en_c);
    // Bypass the array when the byte being written becomes the new head.
    head_c   = (count_left_c == '0) ? in_data : mem[rd_ptr_d];
    busy_d   = (state_d != S_IDLE);

    tx_valid_d = 1'b0;
    tx_data_d  = tx_data;
    case (state_d)
      S_HDR0: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR0;
      end
      S_HDR1: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR1;
      end
      S_SEQ: begin
        tx_valid_d = 1'b1;
        tx_data_d  = frame_seq_d;
      end
      S_PAYLOAD: begin
        if (count_d != '0) begin
          tx_valid_d = 1'b1;
          tx_data_d  = head_c;
        end
      end
      S_TRL_SUM: begin
        tx_valid_d = 1'b1;
        tx_data_d  = checksum_d;
      end
      S_TRL_DROP: begin
        tx_valid_d = 1'b1;
        tx_data_d  = drop_count_d;
      end
      default: ;
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge sys_clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= in_data;
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      accept_q      <= 1'b0;
      end_pending_q <= 1'b0;
      checksum_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      busy          <= 1'b0;
      frame_seq     <= '0;
      drop_count    <= '0;
    end else begin
      state_q       <= state_d;
      accept_q      <= accept_d;
      end_pending_q <= end_pending_d;
      checksum_q    <= checksum_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tx_valid      <= tx_valid_d;
      tx_data       <= tx_data_d;
      busy          <= busy_d;
      frame_seq     <= frame_seq_d;
      drop_count    <= drop_count_d;
    end
  end

endmodule

// File: doc/uart_frame_packetizer.md
Name: uart_frame_packetizer

Overview:
- Sits between the camera frame reader and the UART transmitter.
- Camera bytes arrive as single-cycle strobes, far faster than 115200 baud. The block buffers them in a FIFO and wraps each frame in a header and trailer: header `A5 5A seq`, payload, trailer `checksum drop_count`.
- Bytes go out one at a time over a valid/ready handshake, so the UART TX wrapper can pace the stream and the host can resynchronise and detect loss.

Parameters:
- HDR0, 8'hA5, first header byte.
- HDR1, 8'h5A, second header byte.
- ADDR_W, 8, FIFO address width; depth = 2**ADDR_W (256).

Ports:
- sys_clk  in  1  system clock; every port is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse marking the start of a frame.
- frame_end  in  1  single-cycle pulse marking the end of a frame.
- in_valid  in  1  camera byte strobe; the source cannot stall.
- in_data  in  8  camera byte.
- tx_valid  out  1  an output byte is available.
- tx_data  out  8  output byte.
- tx_ready  in  1  the UART side accepts the byte; a transfer occurs when tx_valid & tx_ready.
- busy  out  1  high whenever the state is not IDLE.
- frame_seq  out  8  sequence number of the current or next frame.
- drop_count  out  8  bytes dropped in the current frame, saturating.

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - tx_valid=0, tx_data=0, busy=0, frame_seq=0, drop_count=0.
  - FIFO empty; checksum=0; accept flag=0; end_pending=0; state=IDLE.
- States: IDLE, HDR0, HDR1, SEQ, PAYLOAD, TRL_SUM, TRL_DROP.
- IDLE:
  - frame_start → HDR0 next cycle.
  - Same edge: accept=1, drop_count=0, checksum=0, FIFO flushed.
  - frame_end in IDLE is ignored.
- HDR0, HDR1, SEQ:
  - tx_valid=1 with tx_data = HDR0, HDR1, frame_seq respectively.
  - Advance on handshake only.
  - Latency: frame_start at cycle t gives tx_valid=1, tx_data=A5 at t+1.
- PAYLOAD:
  - tx_valid = FIFO not empty; tx_data = FIFO head (show-ahead).
  - On handshake: pop the FIFO and add the byte to checksum (mod 256).
  - Exit to TRL_SUM when end_pending=1 and the FIFO is empty; the exit check happens in the cycle after the last pop.
- TRL_SUM, TRL_DROP:
  - Send checksum, then drop_count, each on handshake.
  - After the TRL_DROP handshake: frame_seq += 1 (wraps 255→0), end_pending=0, state → IDLE.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer.
  - tx_ready is ignored while tx_valid=0.
- Write side:
  - in_valid & accept & FIFO not full → write; the byte is visible at the head 1 cycle later.
  - Writes proceed in every non-IDLE state, including during header emission.
  - in_valid & accept & full → byte discarded; drop_count increments, saturating at 255.
  - A write is rejected when full even if a pop happens in the same cycle.
  - in_valid with accept=0 → discarded and not counted.
- frame_end:
  - With accept=1: accept=0, end_pending=1.
  - A byte with in_valid in the same cycle is still written (counted as dropped if full).
- frame_start while not IDLE:
  - Ignored. That frame's bytes are discarded and uncounted because accept stays 0 once the previous frame_end has been seen.
  - frame_start in the same cycle as the final TRL_DROP handshake is also ignored.
- frame_start and in_valid in the same IDLE cycle:
  - The byte belongs to the new frame and is written (accept is treated as already set).
- FIFO:
  - Pointers are ADDR_W bits wide and wrap modulo depth.
  - The occupancy counter is ADDR_W+1 bits; full when count == 2**ADDR_W, empty when count == 0.
- Reset mid-frame: all state is cleared immediately, including mid-handshake; no partial trailer is sent.

Test Plan:
- Reset, then frame_start, 3 bytes (01 02 03), frame_end, with tx_ready=1 throughout → output stream is A5 5A 00 01 02 03 06 00; busy falls after the last byte; frame_seq=1.
- Same frame with tx_ready toggling 1-of-3 cycles → identical byte stream; tx_data is stable every cycle tx_valid=1 & tx_ready=0.
- tx_ready=0, frame_start, 300 bytes of value 01, frame_end, then tx_ready=1 → 256 payload bytes, checksum 00, drop_count 2C (44).
- Send 256 consecutive frames of 1 byte each → seq bytes run 00..FF, then the next frame shows seq=00.
- frame_start during PAYLOAD of frame N, followed by 5 bytes → those bytes are absent from the output; frame N's trailer is unaffected; drop_count is unchanged.
- Assert rst_n low while in PAYLOAD with the FIFO half full → tx_valid=0 and busy=0 immediately; a new frame after reset starts with seq 00.
